ysyx_24100029_wb_arbiter: RTL and testbench

YSYX_24100029_WB_ARBITER -- requirements
Module: ysyx_24100029_wb_arbiter

---
 rtl/ysyx_24100029_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_ysyx_24100029_wb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_wb_arbiter.sv
// Round-robin writeback arbiter (ALU vs LSU) with a per-register pending-write scoreboard.
// Latency: grant is combinational in the request cycle; the register-file write is registered one cycle later.
// Backpressure: a loser's ready stays low until it wins; issue is stalled only when that rd's pending count is saturated.
module ysyx_24100029_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  sb_err
);

    localparam int NREG = 1 << ADDR_WIDTH;

    // rr_lsu=1 means the LSU wins the next contended cycle
    logic            rr_lsu;
    logic            alu_hs;
    logic            lsu_hs;
    logic            contended;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic [1:0]      cnt_q [NREG];
    logic [1:0]      cnt_d [NREG];
    logic            err_set;

    assign contended = alu_valid && lsu_valid;
    assign alu_hs    = alu_valid && alu_ready;
    assign lsu_hs    = lsu_valid && lsu_ready;

    // Grant: sole requester wins, contention resolved by the round-robin pointer; nothing granted in reset
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (reset) begin
            if (contended) begin
                lsu_ready = rr_lsu;
                alu_ready = !rr_lsu;
            end else begin
                alu_ready = alu_valid;
                lsu_ready = lsu_valid;
            end
        end
    end

    // Pointer flips only when both requesters competed, so the loser wins next time
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_lsu <= 1'b1;
        end else if (contended) begin
            rr_lsu <= !rr_lsu;
        end
    end

    // Registered RF write port; writes to x0 are accepted but never asserted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen   <= (alu_hs && (alu_rd != '0)) || (lsu_hs && (lsu_rd != '0));
            rf_waddr <= lsu_hs ? lsu_rd : alu_rd;
            rf_wdata <= lsu_hs ? lsu_data : alu_data;
        end
    end

    // Decode issue (increment) and commit (decrement) into one-hot register vectors
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (iss_valid && iss_ready && (iss_rd != '0)) inc_vec[iss_rd] = 1'b1;
        if (rf_wen) dec_vec[rf_waddr] = 1'b1;
    end

    // Next counts: simultaneous inc/dec cancel; decrementing an empty count flags underflow and holds 0
    always_comb begin
        err_set = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (cnt_q[i] == 2'd0) err_set = 1'b1;
                else                  cnt_d[i] = cnt_q[i] - 2'd1;
            end
        end
    end

    // Pending-count state and sticky underflow flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= 2'd0;
            sb_err <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (err_set) sb_err <= 1'b1;
        end
    end

    // Hazard queries and issue stall read current counts; x0 is never incremented so it reads 0
    assign rs1_busy  = (cnt_q[rs1_addr] != 2'd0);
    assign rs2_busy  = (cnt_q[rs2_addr] != 2'd0);
    assign iss_ready = !((iss_rd != '0) && (cnt_q[iss_rd] == 2'd3));

endmodule

// File: tb/tb_ysyx_24100029_wb_arbiter.sv
// Directed bench for the writeback arbiter and scoreboard.
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
// Expected values are hand-computed per step.
module tb_ysyx_24100029_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, lsu_valid, iss_valid;
    logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1_addr, rs2_addr;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy;
    logic        rf_wen, sb_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    int vec  = 0;
    int errs = 0;

    always #5 clock = ~clock;

    ysyx_24100029_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_err(sb_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        if (obs !== exp) begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state, requests present but must not be granted
        reset = 1'b0;
        alu_valid = 1'b1; lsu_valid = 1'b1; iss_valid = 1'b0;
        alu_rd = 5'd1; lsu_rd = 5'd2; iss_rd = 5'd0;
        alu_data = 32'h0; lsu_data = 32'h0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #3;
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_lsu_ready", lsu_ready, 1'b0);
        chk("rst_rf_wen", rf_wen, 1'b0);
        chk("rst_sb_err", sb_err, 1'b0);
        @(negedge clock);
        reset = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;

        // single ALU write to rd 5, issued in the same cycle
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        iss_valid = 1'b1; iss_rd = 5'd5; rs1_addr = 5'd5;
        #1;
        chk("single_alu_ready", alu_ready, 1'b1);
        chk("single_lsu_ready", lsu_ready, 1'b0);
        chk("single_busy_pre", rs1_busy, 1'b0);
        tick();
        alu_valid = 1'b0; iss_valid = 1'b0;
        #1;
        chk("single_wen", rf_wen, 1'b1);
        chk("single_waddr", rf_waddr, 5'd5);
        chk("single_wdata", rf_wdata, 32'h1234);
        chk("single_busy", rs1_busy, 1'b1);
        tick();
        chk("single_wen_off", rf_wen, 1'b0);
        chk("single_busy_clr", rs1_busy, 1'b0);

        // pre-issue rd 2 twice and rd 1 once for the contention writes
        iss_valid = 1'b1; iss_rd = 5'd2; tick();
        iss_rd = 5'd2; tick();
        iss_rd = 5'd1; tick();
        iss_valid = 1'b0;

        // contention: LSU, ALU, LSU
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2;
        rs1_addr = 5'd2; rs2_addr = 5'd1;
        #1;
        chk("c1_lsu_ready", lsu_ready, 1'b1);
        chk("c1_alu_ready", alu_ready, 1'b0);
        chk("c1_busy2", rs1_busy, 1'b1);
        chk("c1_busy1", rs2_busy, 1'b1);
        tick();
        chk("c2_alu_ready", alu_ready, 1'b1);
        chk("c2_lsu_ready", lsu_ready, 1'b0);
        chk("c2_wen", rf_wen, 1'b1);
        chk("c2_waddr", rf_waddr, 5'd2);
        chk("c2_wdata", rf_wdata, 32'hB2);
        tick();
        chk("c3_lsu_ready", lsu_ready, 1'b1);
        chk("c3_waddr", rf_waddr, 5'd1);
        chk("c3_wdata", rf_wdata, 32'hA1);
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        chk("c4_wen", rf_wen, 1'b1);
        chk("c4_waddr", rf_waddr, 5'd2);
        chk("c4_busy2", rs1_busy, 1'b1);
        chk("c4_busy1", rs2_busy, 1'b0);
        tick();
        chk("c5_wen", rf_wen, 1'b0);
        chk("c5_busy2", rs1_busy, 1'b0);
        chk("c5_sb_err", sb_err, 1'b0);

        // scoreboard: two issues and two commits to rd 7
        iss_valid = 1'b1; iss_rd = 5'd7; tick();
        tick();
        iss_valid = 1'b0; rs1_addr = 5'd7; rs2_addr = 5'd7;
        #1;
        chk("sb_busy_rs1", rs1_busy, 1'b1);
        chk("sb_busy_rs2", rs2_busy, 1'b1);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        #1;
        chk("sb_wen1", rf_wen, 1'b1);
        chk("sb_waddr1", rf_waddr, 5'd7);
        tick();
        chk("sb_busy_after1", rs1_busy, 1'b1);
        alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("sb_busy_after2", rs1_busy, 1'b0);

        // saturation on rd 3
        iss_valid = 1'b1; iss_rd = 5'd3;
        #1;
        chk("sat_ready_first", iss_ready, 1'b1);
        tick(); tick(); tick();
        iss_valid = 1'b0;
        #1;
        chk("sat_ready_rd3", iss_ready, 1'b0);
        iss_rd = 5'd4;
        #1;
        chk("sat_ready_rd4", iss_ready, 1'b1);
        iss_rd = 5'd0;
        #1;
        chk("sat_ready_rd0", iss_ready, 1'b1);
        iss_rd = 5'd3;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        tick();
        chk("sat_still_full", iss_ready, 1'b0);
        tick();
        alu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3;
        #1;
        chk("same_ready", iss_ready, 1'b1);
        chk("same_wen", rf_wen, 1'b1);
        chk("same_waddr", rf_waddr, 5'd3);
        tick();
        chk("same_kept2", iss_ready, 1'b1);
        tick();
        iss_valid = 1'b0;
        #1;
        chk("same_back_to3", iss_ready, 1'b0);
        chk("same_sb_err", sb_err, 1'b0);

        // write to x0 accepted and dropped
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD; rs1_addr = 5'd0;
        #1;
        chk("x0_ready", alu_ready, 1'b1);
        chk("x0_busy", rs1_busy, 1'b0);
        tick();
        alu_valid = 1'b0;
        #1;
        chk("x0_wen", rf_wen, 1'b0);
        chk("x0_sb_err", sb_err, 1'b0);

        // underflow on rd 9
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0;
        #1;
        chk("uf_wen", rf_wen, 1'b1);
        chk("uf_waddr", rf_waddr, 5'd9);
        chk("uf_err_pre", sb_err, 1'b0);
        tick();
        chk("uf_err_set", sb_err, 1'b1);
        tick(); tick();
        chk("uf_err_sticky", sb_err, 1'b1);

        // reset in the cycle after a handshake
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70;
        rs1_addr = 5'd7; rs2_addr = 5'd3;
        tick();
        chk("mr_wen_pre", rf_wen, 1'b1);
        reset = 1'b0;
        #1;
        chk("mr_wen", rf_wen, 1'b0);
        chk("mr_busy7", rs1_busy, 1'b0);
        chk("mr_busy3", rs2_busy, 1'b0);
        chk("mr_sb_err", sb_err, 1'b0);
        chk("mr_alu_ready", alu_ready, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2;
        #1;
        chk("mr_ptr_lsu", lsu_ready, 1'b1);
        chk("mr_ptr_alu", alu_ready, 1'b0);
        chk("mr_no_commit", rf_wen, 1'b0);
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        chk("mr_first_wen", rf_wen, 1'b1);
        chk("mr_first_waddr", rf_waddr, 5'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
